bomb_blast: RTL and testbench

BOMB_BLAST -- requirements
Module: bomb_blast

---
 rtl/bomb_blast.sv | 190 +++++++++++++++++++
 tb/tb_bomb_blast.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_blast.sv
// rtl/bomb_blast.sv - single-bomb fuse, cross-shaped blast scan and flame timer (option: BOMB_PIERCE_EN)
module bomb_blast #(
    parameter int FUSE_CYCLES  = 150,
    parameter int RANGE        = 2,
    parameter int FLAME_CYCLES = 30,
    parameter int COLS         = 20,
    parameter int ROWS         = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        place,
    input  logic [31:0] pos,
    input  logic        win,
    input  logic [31:0] victim_pos,
    output logic [31:0] tile_idx,
    input  logic [31:0] tile_val,
    output logic [31:0] change,
    output logic [31:0] bomb_pos,
    output logic        blast_active,
    output logic        hit
);

    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, FLAME} state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] bomb_nx, change_nx;
    logic [31:0] step, step_nx;
    logic [1:0]  dir, dir_nx;
    logic        centre, centre_nx;
    logic        hit_nx;

    logic [32:0] probe, probe_next;
    logic [3:0]  first_ok;
    logic [2:0]  search_from;
    logic        do_search, go_on, found;
    logic [1:0]  found_dir;

    // Cell reached from b by s steps in direction d (up, down, left, right);
    // the top bit says whether that cell is on the map and, for left/right, on b's row.
    function automatic logic [32:0] cand(input logic [1:0] d, input logic [31:0] s,
                                         input logic [31:0] b);
        logic signed [31:0] base, off, c;
        logic               ok;
        base = $signed(b);
        case (d)
            2'd0:    off = -COLS;
            2'd1:    off = COLS;
            2'd2:    off = -1;
            default: off = 1;
        endcase
        c  = base + off * $signed(s);
        ok = (c >= 0) && (c < CELLS);
        if (d[1] && ok)
            ok = ((c / COLS) == (base / COLS));
        return {ok, c};
    endfunction

    // State and datapath registers; Reset abandons any bomb immediately.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bomb_pos <= '0;
            change   <= '0;
            step     <= '0;
            dir      <= '0;
            centre   <= 1'b0;
            hit      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bomb_pos <= bomb_nx;
            change   <= change_nx;
            step     <= step_nx;
            dir      <= dir_nx;
            centre   <= centre_nx;
            hit      <= hit_nx;
        end
    end

    // Next-state, probe address and the skip-ahead to the next direction with a legal first step.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bomb_nx      = bomb_pos;
        change_nx    = '0;
        step_nx      = step;
        dir_nx       = dir;
        centre_nx    = centre;
        hit_nx       = hit;
        tile_idx     = bomb_pos;
        blast_active = (state == SCAN) || (state == FLAME);
        search_from  = 3'd0;
        do_search    = 1'b0;
        go_on        = 1'b0;
        found        = 1'b0;
        found_dir    = 2'd0;
        probe        = cand(dir, step, bomb_pos);
        probe_next   = cand(dir, step + 32'd1, bomb_pos);
        for (int k = 0; k < 4; k++) begin
            logic [32:0] c1;
            c1          = cand(2'(k), 32'd1, bomb_pos);
            first_ok[k] = c1[32];
        end

        case (state)
            IDLE: begin
                hit_nx = 1'b0;
                if (place && (pos != 32'd0) && (pos < 32'(CELLS))) begin
                    bomb_nx  = pos;
                    cnt_nx   = 32'(FUSE_CYCLES - 1);
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (cnt == 32'd0) begin
                    state_nx  = SCAN;
                    centre_nx = 1'b1;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            SCAN: begin
                if (centre) begin
                    centre_nx = 1'b0;
                    do_search = 1'b1;
                end else begin
                    tile_idx = probe[31:0];
                    if (tile_val == 32'd0) begin
                        go_on = 1'b1;
                    end else if (tile_val == 32'd2) begin
                        change_nx = probe[31:0];
`ifdef BOMB_PIERCE_EN
                        go_on = 1'b1;
`else
                        go_on = 1'b0;
`endif
                    end
                    if (go_on && (step < 32'(RANGE)) && probe_next[32]) begin
                        step_nx = step + 32'd1;
                    end else begin
                        do_search   = 1'b1;
                        search_from = {1'b0, dir} + 3'd1;
                    end
                end
                if (tile_idx == victim_pos)
                    hit_nx = 1'b1;
            end
            FLAME: begin
                if (cnt == 32'd0) begin
                    state_nx = IDLE;
                    bomb_nx  = '0;
                    hit_nx   = 1'b0;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        for (int k = 0; k < 4; k++) begin
            if (!found && (3'(k) >= search_from) && first_ok[k]) begin
                found     = 1'b1;
                found_dir = 2'(k);
            end
        end
        if (do_search) begin
            if (found) begin
                dir_nx  = found_dir;
                step_nx = 32'd1;
            end else begin
                state_nx = FLAME;
                cnt_nx   = 32'(FLAME_CYCLES - 1);
            end
        end

        if (win) begin
            state_nx  = IDLE;
            bomb_nx   = '0;
            change_nx = '0;
            hit_nx    = 1'b0;
            cnt_nx    = '0;
            centre_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_bomb_blast.sv
// tb/tb_bomb_blast.sv - scoreboard bench for bomb_blast on a walled 20x15 map
module tb_bomb_blast;

    localparam int FUSE  = 4;
    localparam int RNG   = 2;
    localparam int FLAME = 6;
    localparam int COLS  = 20;
    localparam int ROWS  = 15;

    logic        Clk = 1'b0;
    logic        Reset, place, win;
    logic [31:0] pos, victim_pos, tile_idx, tile_val, change, bomb_pos;
    logic        blast_active, hit;

    typedef struct {int cyc; int val;} ev_t;

    int   map [COLS*ROWS];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    ev_t  exp_probe[$];
    ev_t  exp_chg[$];
    ev_t  mon_e;
    int   seq[$];
    int   forbid = -1;
    int   forbid_seen = 0;
    int   active_seen = 0;

    bomb_blast #(.FUSE_CYCLES(FUSE), .RANGE(RNG), .FLAME_CYCLES(FLAME), .COLS(COLS), .ROWS(ROWS)) dut (
        .Clk(Clk), .Reset(Reset), .place(place), .pos(pos), .win(win),
        .victim_pos(victim_pos), .tile_idx(tile_idx), .tile_val(tile_val),
        .change(change), .bomb_pos(bomb_pos), .blast_active(blast_active), .hit(hit)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    assign tile_val = (tile_idx < 32'(COLS*ROWS)) ? 32'(map[tile_idx[8:0]]) : 32'd1;

    // Scoreboard: probe addresses and cleared tiles are popped at their expected cycle.
    always @(negedge Clk) begin
        if (blast_active) active_seen++;
        if (blast_active && forbid >= 0 && tile_idx == 32'(forbid)) forbid_seen++;
        if (exp_probe.size() > 0 && exp_probe[0].cyc == cyc) begin
            mon_e = exp_probe.pop_front();
            total++;
            if (tile_idx !== 32'(mon_e.val))
                $display("FAIL probe@%0d got %0d want %0d", cyc, tile_idx, mon_e.val);
            else passed++;
        end
        if (exp_chg.size() > 0 && exp_chg[0].cyc == cyc) begin
            mon_e = exp_chg.pop_front();
            total++;
            if (change !== 32'(mon_e.val))
                $display("FAIL change@%0d got %0d want %0d", cyc, change, mon_e.val);
            else passed++;
        end else if (change !== 32'd0) begin
            total++;
            $display("FAIL stray_change@%0d got %0d want 0", cyc, change);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    task automatic place_bomb(input int p, output int t0);
        place = 1'b1;
        pos   = 32'(p);
        t0    = cyc;
        @(negedge Clk);
        place = 1'b0;
        pos   = 32'd0;
    endtask

    task automatic push_scan(input int t0);
        foreach (seq[i]) exp_probe.push_back('{t0 + 5 + i, seq[i]});
    endtask

    task automatic test_reset();
        Reset = 1'b1; place = 1'b0; win = 1'b0; pos = '0; victim_pos = 32'd299;
        repeat (2) @(negedge Clk);
        total++; if (bomb_pos !== 32'd0) $display("FAIL rst_bomb_pos got %0d want 0", bomb_pos); else passed++;
        total++; if (tile_idx !== 32'd0) $display("FAIL rst_tile_idx got %0d want 0", tile_idx); else passed++;
        total++; if (blast_active !== 1'b0) $display("FAIL rst_active got %b want 0", blast_active); else passed++;
        total++; if (hit !== 1'b0) $display("FAIL rst_hit got %b want 0", hit); else passed++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        int t0, last;
`ifdef BOMB_PIERCE_EN
        seq = '{21, 1, 41, 61, 20, 22, 23};
        forbid = -1;
`else
        seq = '{21, 1, 41, 20, 22, 23};
        forbid = 61;
`endif
        forbid_seen = 0;
        place_bomb(21, t0);
        push_scan(t0);
        exp_chg.push_back('{t0 + 8, 41});
        last = t0 + 4 + seq.size() + FLAME;
        wait_cyc(t0 + 4);
        total++; if (blast_active !== 1'b0) $display("FAIL fuse_early got %b want 0", blast_active); else passed++;
        wait_cyc(t0 + 5);
        total++; if (blast_active !== 1'b1) $display("FAIL scan_start got %b want 1", blast_active); else passed++;
        wait_cyc(last);
        total++; if (blast_active !== 1'b1 || bomb_pos !== 32'd21)
            $display("FAIL flame_end got active=%b pos=%0d want 1/21", blast_active, bomb_pos); else passed++;
        wait_cyc(last + 1);
        total++; if (blast_active !== 1'b0 || bomb_pos !== 32'd0)
            $display("FAIL idle_after got active=%b pos=%0d want 0/0", blast_active, bomb_pos); else passed++;
        total++; if (exp_probe.size() != 0 || exp_chg.size() != 0)
            $display("FAIL basic_drain got %0d/%0d want 0/0", exp_probe.size(), exp_chg.size()); else passed++;
        total++; if (forbid_seen != 0) $display("FAIL tile61_probed got %0d want 0", forbid_seen); else passed++;
    endtask

    task automatic test_row_edge();
        int t0;
        forbid = 40;
        forbid_seen = 0;
        seq = '{38, 18, 58, 78, 37, 36, 39};
        place_bomb(38, t0); push_scan(t0); wait_cyc(t0 + 5 + seq.size() + FLAME + 1);
        seq = '{39, 19, 59, 38, 37};
        place_bomb(39, t0); push_scan(t0); wait_cyc(t0 + 5 + seq.size() + FLAME + 1);
        forbid = -1;
        seq = '{5, 25, 45, 4, 6};
        place_bomb(5, t0); push_scan(t0); wait_cyc(t0 + 5 + seq.size() + FLAME + 1);
        total++; if (forbid_seen != 0) $display("FAIL tile40_probed got %0d want 0", forbid_seen); else passed++;
        total++; if (exp_probe.size() != 0) $display("FAIL edge_drain got %0d want 0", exp_probe.size()); else passed++;
    endtask

    task automatic test_hit();
        int t0, p23, last;
`ifdef BOMB_PIERCE_EN
        seq = '{21, 1, 41, 61, 20, 22, 23};
`else
        seq = '{21, 1, 41, 20, 22, 23};
`endif
        map[41] = 2;
        victim_pos = 32'd23;
        place_bomb(21, t0); push_scan(t0);
        exp_chg.push_back('{t0 + 8, 41});
        p23  = t0 + 4 + seq.size();
        last = t0 + 4 + seq.size() + FLAME;
        wait_cyc(p23);
        total++; if (hit !== 1'b0) $display("FAIL hit_early got %b want 0", hit); else passed++;
        wait_cyc(p23 + 1);
        total++; if (hit !== 1'b1) $display("FAIL hit_rise got %b want 1", hit); else passed++;
        wait_cyc(last);
        total++; if (hit !== 1'b1) $display("FAIL hit_hold got %b want 1", hit); else passed++;
        wait_cyc(last + 1);
        total++; if (hit !== 1'b0) $display("FAIL hit_idle got %b want 0", hit); else passed++;
        victim_pos = 32'd100;
        place_bomb(21, t0); push_scan(t0);
        exp_chg.push_back('{t0 + 8, 41});
        wait_cyc(t0 + 4 + seq.size() + FLAME);
        total++; if (hit !== 1'b0) $display("FAIL hit_miss got %b want 0", hit); else passed++;
        wait_cyc(t0 + 5 + seq.size() + FLAME + 1);
        victim_pos = 32'd299;
    endtask

    task automatic test_back_to_back();
        int t0;
`ifdef BOMB_PIERCE_EN
        seq = '{21, 1, 41, 61, 20, 22, 23};
`else
        seq = '{21, 1, 41, 20, 22, 23};
`endif
        place_bomb(21, t0); push_scan(t0);
        exp_chg.push_back('{t0 + 8, 41});
        wait_cyc(t0 + 2);
        place = 1'b1; pos = 32'd50;
        @(negedge Clk);
        place = 1'b0; pos = 32'd0;
        total++; if (bomb_pos !== 32'd21) $display("FAIL second_place got %0d want 21", bomb_pos); else passed++;
        wait_cyc(t0 + 5 + seq.size() + FLAME + 3);
        total++; if (blast_active !== 1'b0 || bomb_pos !== 32'd0)
            $display("FAIL no_second_bomb got active=%b pos=%0d want 0/0", blast_active, bomb_pos); else passed++;
    endtask

    task automatic test_win();
        int t0;
        seq = '{21, 1, 41};
        place_bomb(21, t0); push_scan(t0);
        wait_cyc(t0 + 7);
        win = 1'b1;
        @(negedge Clk);
        win = 1'b0;
        total++; if (blast_active !== 1'b0) $display("FAIL win_active got %b want 0", blast_active); else passed++;
        total++; if (change !== 32'd0) $display("FAIL win_change got %0d want 0", change); else passed++;
        total++; if (bomb_pos !== 32'd0 || tile_idx !== 32'd0)
            $display("FAIL win_pos got %0d/%0d want 0/0", bomb_pos, tile_idx); else passed++;
        wait_cyc(t0 + 20);
    endtask

    task automatic test_reset_mid();
        int t0, seen;
        place_bomb(21, t0);
        wait_cyc(t0 + 2);
        Reset = 1'b1;
        #1;
        total++; if (bomb_pos !== 32'd0 || tile_idx !== 32'd0 || blast_active !== 1'b0 || hit !== 1'b0)
            $display("FAIL mid_reset got pos=%0d idx=%0d act=%b hit=%b want 0", bomb_pos, tile_idx, blast_active, hit);
        else passed++;
        @(negedge Clk);
        Reset = 1'b0;
        seen = active_seen;
        repeat (20) @(negedge Clk);
        total++; if (active_seen != seen || bomb_pos !== 32'd0)
            $display("FAIL after_reset got blasts=%0d pos=%0d want 0/0", active_seen - seen, bomb_pos); else passed++;
    endtask

    initial begin
        for (int i = 0; i < COLS*ROWS; i++)
            map[i] = (i < COLS || i >= (ROWS-1)*COLS || (i % COLS) == 0 || (i % COLS) == COLS-1) ? 1 : 0;
        map[41] = 2;
        test_reset();
        test_basic();
        test_row_edge();
        test_hit();
        test_back_to_back();
        test_win();
        test_reset_mid();
        total++; if (exp_probe.size() != 0 || exp_chg.size() != 0)
            $display("FAIL final_drain got %0d/%0d want 0/0", exp_probe.size(), exp_chg.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
